// File: rtl/fare_display.sv
// -----------------------------------------------------------------------------
// fare_display
//
// Consumer side of the fare counter. A load strobe samples the 10-bit binary
// fare, clamps it to 999 and converts it to three BCD digits with an iterative
// shift-add-3 (double-dabble) engine, one bit per clock. The committed BCD
// value feeds a free-running, time-multiplexed driver for an active-low
// 3-digit 7-segment display, with optional leading-zero blanking.
//
// Parameters
//   SCAN_DIV : clock cycles per digit scan slot (>= 2)
//   BLANK_LZ : 1 = blank leading zeros on hundreds/tens, 0 = show all digits
//
// Ports
//   clk     in   1   system clock, rising edge
//   rst     in   1   synchronous reset, active-low
//   fare    in  10   binary fare from the fare counter
//   load    in   1   single-cycle conversion request (ignored while busy)
//   busy    out  1   conversion in progress
//   done    out  1   one-cycle pulse when bcd has been updated
//   bcd     out 12   committed result {hundreds, tens, ones}
//   dig_sel out  3   digit enables, active-low; bit0 ones, bit1 tens, bit2 hundreds
//   seg     out  7   segments, active-low, order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module fare_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  fare,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [2:0]  dig_sel,
  output logic [6:0]  seg
);

  localparam int              CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [9:0]      FARE_MAX  = 10'd999;
  localparam logic [3:0]      ITER_LAST = 4'd9;
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;
  localparam logic [2:0]      SEL_NONE  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Saturate the incoming fare to the largest value three digits can show.
  function automatic logic [9:0] clamp_fare(input logic [9:0] f);
    return (f > FARE_MAX) ? FARE_MAX : f;
  endfunction

  // Double-dabble correction: a nibble >= 5 would become >= 10 after the
  // shift, so pre-add 3 to carry into the next decade instead.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Active-low {g,f,e,d,c,b,a} code for a BCD digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Scan order ones -> tens -> hundreds -> ones.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : (i + 2'd1);
  endfunction

  // Active-low enable pattern for a digit index.
  function automatic logic [2:0] sel_code(input logic [1:0] i);
    logic [2:0] s;
    case (i)
      2'd0:    s = 3'b110;
      2'd1:    s = 3'b101;
      2'd2:    s = 3'b011;
      default: s = SEL_NONE;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,    state_d;
  logic [9:0]       shreg_q,    shreg_d;
  logic [11:0]      work_q,     work_d;
  logic [3:0]       iter_q,     iter_d;
  logic [11:0]      bcd_q,      bcd_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       dig_idx_q,  dig_idx_d;
  logic [2:0]       dig_sel_q,  dig_sel_d;
  logic [6:0]       seg_q,      seg_d;

  // ---------------------------------------------------------------------------
  // Conversion datapath: one add-3 / shift iteration
  // ---------------------------------------------------------------------------
  logic [11:0] work_adj;
  logic [21:0] dabble_sh;
  logic [11:0] work_nxt;
  logic [9:0]  shreg_nxt;

  always_comb begin
    work_adj  = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
    // The working value never exceeds 999, so nothing useful leaves the top.
    dabble_sh = {work_adj, shreg_q} << 1;
    work_nxt  = dabble_sh[21:10];
    shreg_nxt = dabble_sh[9:0];
  end

  // ---------------------------------------------------------------------------
  // Conversion FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    work_d  = work_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shreg_d = clamp_fare(fare);
          work_d  = 12'd0;
          iter_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end
      end

      ST_CONV: begin
        // load is deliberately not examined here: requests while busy drop.
        shreg_d = shreg_nxt;
        work_d  = work_nxt;
        iter_d  = iter_q + 4'd1;
        if (iter_q == ITER_LAST) begin
          bcd_d   = work_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Display scan next-state
  // ---------------------------------------------------------------------------
  logic       scan_tick;
  logic [1:0] idx_nxt;
  logic [3:0] show_digit;
  logic       show_blank;
  logic       hund_zero;
  logic       tens_zero;

  always_comb begin
    scan_tick  = (scan_cnt_q == CNT_LAST);
    idx_nxt    = next_idx(dig_idx_q);
    hund_zero  = (bcd_q[11:8] == 4'd0);
    tens_zero  = (bcd_q[7:4] == 4'd0);

    // Digit and blanking decision for the slot about to be entered.
    case (idx_nxt)
      2'd0: begin
        show_digit = bcd_q[3:0];
        show_blank = 1'b0;
      end
      2'd1: begin
        show_digit = bcd_q[7:4];
        show_blank = BLANK_LZ && hund_zero && tens_zero;
      end
      default: begin
        show_digit = bcd_q[11:8];
        show_blank = BLANK_LZ && hund_zero;
      end
    endcase

    scan_cnt_d = scan_cnt_q;
    dig_idx_d  = dig_idx_q;
    dig_sel_d  = dig_sel_q;
    seg_d      = seg_q;

    if (scan_tick) begin
      scan_cnt_d = '0;
      dig_idx_d  = idx_nxt;
      dig_sel_d  = sel_code(idx_nxt);
      seg_d      = show_blank ? SEG_BLANK : seg_code(show_digit);
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      iter_q     <= 4'd0;
      bcd_q      <= 12'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scan_cnt_q <= '0;
      dig_idx_q  <= 2'd0;
      dig_sel_q  <= SEL_NONE;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
      dig_sel_q  <= dig_sel_d;
      seg_q      <= seg_d;
    end
    // Working registers are fully initialised on every accepted load.
    shreg_q <= shreg_d;
    work_q  <= work_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign dig_sel = dig_sel_q;
  assign seg     = seg_q;

endmodule

// File: tb/tb_fare_display.sv
module tb_fare_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [9:0]  fare;

  logic        busy_a, done_a, busy_b, done_b;
  logic [11:0] bcd_a, bcd_b;
  logic [2:0]  dig_sel_a, dig_sel_b;
  logic [6:0]  seg_a, seg_b;

  int checks = 0;
  int fails  = 0;

  fare_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .fare(fare), .load(load),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .dig_sel(dig_sel_a), .seg(seg_a)
  );

  fare_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .fare(fare), .load(load),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .dig_sel(dig_sel_b), .seg(seg_b)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Behavioural reference: decimal value as an integer, countdown to commit,
  // scan position as a cycle count.
  int         m_val;
  int         m_pend;
  int         m_rem;
  bit         m_busy;
  bit         m_done;
  int         m_cnt;
  int         m_idx;
  logic [2:0] m_dsel;
  logic [6:0] m_seg;
  logic [6:0] m_seg0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx, input bit blank);
    int h, t, o, d;
    bit bl;
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    d  = (idx == 0) ? o : (idx == 1) ? t : h;
    bl = blank && (((idx == 2) && (h == 0)) || ((idx == 1) && (v < 10)));
    return bl ? 7'b1111111 : seg_tab[d];
  endfunction

  always @(posedge clk) begin : model
    int nidx;
    if (!rst) begin
      m_val  <= 0;
      m_rem  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_idx  <= 0;
      m_dsel <= 3'b111;
      m_seg  <= 7'b1111111;
      m_seg0 <= 7'b1111111;
    end else begin
      if (m_cnt == SD - 1) begin
        nidx = (m_idx + 1) % 3;
        m_cnt  <= 0;
        m_idx  <= nidx;
        m_dsel <= ~(3'b001 << nidx);
        m_seg  <= exp_seg(m_val, nidx, 1'b1);
        m_seg0 <= exp_seg(m_val, nidx, 1'b0);
      end else begin
        m_cnt <= m_cnt + 1;
      end
      m_done <= 1'b0;
      if (!m_busy) begin
        if (load) begin
          m_pend <= (int'(fare) > 999) ? 999 : int'(fare);
          m_rem  <= 10;
          m_busy <= 1'b1;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_val  <= m_pend;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare every output of both instances to the model.
  task automatic cyc();
    @(posedge clk);
    #1;
    chk("busy",      32'(busy_a),    32'(m_busy));
    chk("done",      32'(done_a),    32'(m_done));
    chk("bcd",       32'(bcd_a),     32'(to_bcd(m_val)));
    chk("dig_sel",   32'(dig_sel_a), 32'(m_dsel));
    chk("seg",       32'(seg_a),     32'(m_seg));
    chk("bcd_nolz",  32'(bcd_b),     32'(to_bcd(m_val)));
    chk("done_nolz", 32'(done_b),    32'(m_done));
    chk("sel_nolz",  32'(dig_sel_b), 32'(m_dsel));
    chk("seg_nolz",  32'(seg_b),     32'(m_seg0));
  endtask

  task automatic do_load(input logic [9:0] v);
    fare = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (done_a === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Wait for the scan to enter slot `sel`, then compare both segment outputs.
  task automatic see_digit(input logic [2:0] sel, input logic [6:0] exp_a,
                           input logic [6:0] exp_b, input string tag);
    logic [2:0] prev;
    bit found;
    found = 1'b0;
    prev  = dig_sel_a;
    for (int i = 0; i < 3 * SD + 2; i++) begin
      cyc();
      if (dig_sel_a === sel && prev !== sel) begin
        found = 1'b1;
        break;
      end
      prev = dig_sel_a;
    end
    chk({tag, "_slot"}, 32'(found), 32'd1);
    chk({tag, "_seg"},  32'(seg_a), 32'(exp_a));
    chk({tag, "_segb"}, 32'(seg_b), 32'(exp_b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    rst  = 1'b0;
    load = 1'b0;
    fare = 10'd0;
    repeat (3) cyc();
    chk("rst_busy",    32'(busy_a),    32'd0);
    chk("rst_done",    32'(done_a),    32'd0);
    chk("rst_bcd",     32'(bcd_a),     32'h000);
    chk("rst_dig_sel", 32'(dig_sel_a), 32'b111);
    chk("rst_seg",     32'(seg_a),     32'h7f);
    rst = 1'b1;
    cyc();

    // Fare 3: latency and display of a single digit.
    do_load(10'd3);
    chk("busy_after_load", 32'(busy_a), 32'd1);
    wait_done(lat);
    chk("latency_3", 32'(lat), 32'd10);
    chk("bcd_3", 32'(bcd_a), 32'h003);
    cyc();
    chk("done_single", 32'(done_a), 32'd0);
    see_digit(3'b110, 7'b0110000, 7'b0110000, "d3_ones");
    see_digit(3'b101, 7'b1111111, 7'b1000000, "d3_tens");
    see_digit(3'b011, 7'b1111111, 7'b1000000, "d3_hund");

    // Upper boundary, clamping, zero.
    do_load(10'd999);
    wait_done(lat);
    chk("bcd_999", 32'(bcd_a), 32'h999);
    do_load(10'd1023);
    wait_done(lat);
    chk("bcd_clamp", 32'(bcd_a), 32'h999);
    do_load(10'd0);
    wait_done(lat);
    chk("bcd_0", 32'(bcd_a), 32'h000);
    see_digit(3'b110, 7'b1000000, 7'b1000000, "d0_ones");
    see_digit(3'b101, 7'b1111111, 7'b1000000, "d0_tens");
    see_digit(3'b011, 7'b1111111, 7'b1000000, "d0_hund");

    // Loads while busy are dropped, including on the committing edge.
    do_load(10'd5);                 // edge k
    repeat (3) cyc();               // edges k+1..k+3
    fare = 10'd100;
    load = 1'b1;
    cyc();                          // edge k+4: ignored
    chk("busy_k4", 32'(busy_a), 32'd1);
    load = 1'b0;
    repeat (5) cyc();               // edges k+5..k+9
    load = 1'b1;
    cyc();                          // edge k+10: commit, load ignored
    chk("done_k10", 32'(done_a), 32'd1);
    chk("bcd_5", 32'(bcd_a), 32'h005);
    cyc();                          // edge k+11: accepted
    load = 1'b0;
    chk("busy_k11", 32'(busy_a), 32'd1);
    wait_done(lat);
    chk("latency_100", 32'(lat), 32'd10);
    chk("bcd_100", 32'(bcd_a), 32'h100);
    see_digit(3'b101, 7'b1000000, 7'b1000000, "d100_tens");
    see_digit(3'b011, 7'b1111001, 7'b1111001, "d100_hund");

    // Fare 250: slot dwell and per-digit codes.
    do_load(10'd250);
    wait_done(lat);
    chk("bcd_250", 32'(bcd_a), 32'h250);
    see_digit(3'b110, 7'b1000000, 7'b1000000, "d250_ones");
    n = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (dig_sel_a !== 3'b110) break;
      n++;
    end
    chk("dwell_ones", 32'(n), 32'd4);
    chk("d250_tens_sel", 32'(dig_sel_a), 32'b101);
    chk("d250_tens_seg", 32'(seg_a), 32'(7'b0010010));
    n = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (dig_sel_a !== 3'b101) break;
      n++;
    end
    chk("dwell_tens", 32'(n), 32'd4);
    chk("d250_hund_sel", 32'(dig_sel_a), 32'b011);
    chk("d250_hund_seg", 32'(seg_a), 32'(7'b0100100));

    // Reset in the middle of a conversion.
    do_load(10'd888);               // edge k
    repeat (4) cyc();               // edges k+1..k+4
    rst = 1'b0;
    cyc();                          // edge k+5: reset
    chk("mid_rst_bcd",  32'(bcd_a),     32'h000);
    chk("mid_rst_busy", 32'(busy_a),    32'd0);
    chk("mid_rst_done", 32'(done_a),    32'd0);
    chk("mid_rst_sel",  32'(dig_sel_a), 32'b111);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (done_a === 1'b1) n++;
    end
    chk("no_done_after_rst", 32'(n), 32'd0);
    do_load(10'd42);
    wait_done(lat);
    chk("bcd_42", 32'(bcd_a), 32'h042);

    // Fare 7 on both blanking settings.
    do_load(10'd7);
    wait_done(lat);
    chk("bcd_7", 32'(bcd_b), 32'h007);
    see_digit(3'b011, 7'b1111111, 7'b1000000, "d7_hund");
    see_digit(3'b110, 7'b1111000, 7'b1111000, "d7_ones");
    see_digit(3'b101, 7'b1111111, 7'b1000000, "d7_tens");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       fare = 10'($urandom_range(995, 1023));
        1:       fare = 10'($urandom_range(0, 12));
        default: fare = 10'($urandom_range(0, 1023));
      endcase
      load = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 149) != 0);
      cyc();
    end
    load = 1'b0;
    rst  = 1'b1;
    repeat (15) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
